instr_encoder: RTL and testbench

- Inverse of the decode-stage field extraction: accepts instruction fields (opcode, rd, rs, rt, shamt, aluop, immediate, target) and packs them into 32-bit instruction words in the processor's ISA format.
- Buffers encoded words in a small FIFO and emits each with a sequential instruction-memory address.
- Used by the boot/self-test program loader to write imem without an external assembler.

---
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into ISA words and streams them with sequential imem addresses
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [4:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            shamt,
    input  logic [4:0]            aluop,
    input  logic [31:0]           imm,
    input  logic [31:0]           target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_opcode,
    output logic                  err_range
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [31:0]           mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic [PW:0]           count_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic                  bad_op;
    logic                  bad_range;
    logic                  full;
    logic                  push;
    logic                  pop;

    always_comb begin
        word      = '0;
        bad_op    = 1'b0;
        bad_range = 1'b0;
        case (opcode)
            5'b00000: word = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
            5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b10000: begin
                word      = {opcode, rd, rs, imm[16:0]};
                bad_range = !((&imm[31:16]) || !(|imm[31:16]));
            end
            5'b00001, 5'b00011: begin
                word      = {opcode, target[26:0]};
                bad_range = |target[31:27];
            end
            5'b10101, 5'b10110: begin
                word      = {opcode, target[26:0]};
                bad_range = !((&target[31:26]) || !(|target[31:26]));
            end
            5'b00100: word = {opcode, rd, 22'b0};
            default:  bad_op = 1'b1;
        endcase
    end

    // A full FIFO blocks acceptance even if the head is leaving this cycle.
    assign full      = (count == (PW+1)'(DEPTH));
    assign in_ready  = (state == RUN) && !full;
    assign push      = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem[rd_ptr] : '0;
    assign out_addr  = out_valid ? addr : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr       <= BASE_ADDR;
            done       <= 1'b0;
            err_opcode <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            done  <= 1'b0;
            count <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr   <= addr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        addr       <= BASE_ADDR;
                        err_opcode <= 1'b0;
                        err_range  <= 1'b0;
                    end
                end
                RUN: begin
                    if (push) begin
                        err_opcode <= err_opcode | bad_op;
                        err_range  <= err_range | bad_range;
                        if (in_last)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Pulse done as soon as the last word has left.
                    if (count_nxt == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with directed field bundles
module tb_instr_encoder;
    logic        clock = 1'b0;
    logic        reset, reset_b, sel;
    logic        start, in_valid, in_last, out_ready;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [31:0] imm, target;

    logic        in_ready1, out_valid1, busy1, done1, err_opcode1, err_range1;
    logic [31:0] out_instr1;
    logic [11:0] out_addr1;
    logic        in_ready2, out_valid2, busy2, done2, err_opcode2, err_range2;
    logic [31:0] out_instr2;
    logic [11:0] out_addr2;

    int checks = 0;
    int errors = 0;
    int dones1 = 0;
    int dones2 = 0;
    logic [11:0] a1, a2;
    logic [43:0] q1 [$];
    logic [43:0] q2 [$];

    always #5 clock = ~clock;

    instr_encoder u_dut1 (
        .clock(clock), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_ready(in_ready1), .in_last(in_last), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .shamt(shamt), .aluop(aluop), .imm(imm), .target(target), .out_valid(out_valid1),
        .out_ready(out_ready), .out_instr(out_instr1), .out_addr(out_addr1), .busy(busy1),
        .done(done1), .err_opcode(err_opcode1), .err_range(err_range1)
    );

    instr_encoder #(.BASE_ADDR(12'd4094)) u_dut2 (
        .clock(clock), .reset(reset | reset_b), .start(start & sel), .in_valid(in_valid & sel),
        .in_ready(in_ready2), .in_last(in_last), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .shamt(shamt), .aluop(aluop), .imm(imm), .target(target), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2), .busy(busy2),
        .done(done2), .err_opcode(err_opcode2), .err_range(err_range2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done1) dones1++;
        if (done2) dones2++;
        if (out_valid1) begin
            if (q1.size() == 0) check("dut1 unexpected word", {20'h0, out_addr1, out_instr1}, 64'h0);
            else begin
                check("dut1 addr/instr", {20'h0, out_addr1, out_instr1}, {20'h0, q1[0]});
                if (out_ready) void'(q1.pop_front());
            end
        end
        if (out_valid2) begin
            if (q2.size() == 0) check("dut2 unexpected word", {20'h0, out_addr2, out_instr2}, 64'h0);
            else begin
                check("dut2 addr/instr", {20'h0, out_addr2, out_instr2}, {20'h0, q2[0]});
                if (out_ready) void'(q2.pop_front());
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (sel) a2 = 12'd4094; else a1 = 12'd0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs,
                        input logic [4:0] f_rt, input logic [4:0] f_sh, input logic [4:0] f_al,
                        input logic [31:0] f_imm, input logic [31:0] f_tg, input logic last,
                        input logic [31:0] exp);
        logic ok;
        int n;
        opcode = op; rd = f_rd; rs = f_rs; rt = f_rt; shamt = f_sh; aluop = f_al;
        imm = f_imm; target = f_tg; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clock);
            ok = sel ? in_ready2 : in_ready1;
            @(posedge clock);
            if (ok) begin
                if (sel) begin q2.push_back({a2, exp}); a2 = a2 + 12'd1; end
                else begin q1.push_back({a1, exp}); a1 = a1 + 12'd1; end
            end
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) check("accept timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int n;
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clock);
            seen = sel ? done2 : done1;
            n++;
        end
        check("done seen", {63'h0, seen}, 64'd1);
        @(negedge clock);
        check("done one cycle", {63'h0, sel ? done2 : done1}, 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; reset_b = 1'b0; sel = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; opcode = '0; rd = '0; rs = '0; rt = '0; shamt = '0; aluop = '0;
        imm = '0; target = '0; a1 = '0; a2 = 12'd4094;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset outputs",
              {7'h0, in_ready1, out_valid1, busy1, done1, err_opcode1, err_range1, out_addr1, out_instr1},
              64'h0);
        @(posedge clock); #1;

        pulse_start();
        @(negedge clock);
        check("busy in run", {63'h0, busy1}, 64'd1);
        @(posedge clock); #1;
        send(5'b00101, 5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h28C3FFFF);
        wait_done();
        check("err_range addi -1", {63'h0, err_range1}, 64'd0);

        pulse_start();
        send(5'b00000, 5'd4, 5'd2, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h01043000);
        send(5'b00100, 5'd31, 5'd7, 5'd9, 5'd3, 5'd1, 32'h1234, 32'h5678, 1'b1, 32'h27C00000);
        wait_done();

        pulse_start();
        send(5'b10101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'd5, 1'b0, 32'hA8000005);
        send(5'b10101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'hAFFFFFFF);
        @(negedge clock);
        check("err_range setx", {63'h0, err_range1}, 64'd0);
        @(posedge clock); #1;
        send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0800_0000, 1'b1, 32'h08000000);
        wait_done();
        check("err_range j", {63'h0, err_range1}, 64'd1);

        pulse_start();
        send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0001_0000, 32'h0, 1'b0, 32'h28010000);
        @(negedge clock);
        check("err_range addi", {62'h0, err_range1, err_opcode1}, 64'd2);
        @(posedge clock); #1;
        send(5'b11111, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 32'hFFFF, 32'hFFFF, 1'b1, 32'h00000000);
        wait_done();
        check("errors sticky", {62'h0, err_range1, err_opcode1}, 64'd3);
        pulse_start();
        @(negedge clock);
        check("start clears errors", {62'h0, err_range1, err_opcode1}, 64'd0);
        @(posedge clock); #1;

        out_ready = 1'b0;
        send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd1, 32'h0, 1'b0, 32'h28400001);
        send(5'b00101, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'd2, 32'h0, 1'b0, 32'h28800002);
        send(5'b00101, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0, 1'b0, 32'h28C00003);
        send(5'b00101, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 32'd4, 32'h0, 1'b0, 32'h29000004);
        fork
            send(5'b00101, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'd5, 32'h0, 1'b1, 32'h29400005);
            begin
                repeat (3) begin
                    @(negedge clock);
                    check("in_ready low when full", {63'h0, in_ready1}, 64'd0);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
                @(negedge clock);
                check("no bypass on pop", {63'h0, in_ready1}, 64'd0);
            end
        join
        wait_done();
        check("dut1 queue drained", 64'(q1.size()), 64'd0);

        sel = 1'b1;
        pulse_start();
        send(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h20400000);
        send(5'b00100, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h20800000);
        send(5'b00100, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h20C00000);
        wait_done();
        check("dut2 queue drained", 64'(q2.size()), 64'd0);

        out_ready = 1'b0;
        pulse_start();
        send(5'b00100, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h21000000);
        send(5'b00100, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h21400000);
        reset_b = 1'b1;
        @(posedge clock); #1;
        reset_b = 1'b0;
        q2.delete();
        @(negedge clock);
        check("reset flush", {62'h0, out_valid2, busy2}, 64'd0);
        begin
            int d0;
            d0 = dones2;
            out_ready = 1'b1;
            repeat (5) @(negedge clock);
            check("no done after reset", 64'(dones2), 64'(d0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
